merge_sort_iter: RTL
====================

Name: merge_sort_iter

Overview:
- Parametrised successor to the fixed 8-entry merge-sort top used in the BWT rotation sorter.
- Sorts STRING_LEN = 2^LOG_LEN multi-byte elements with one shared comparator and ping-pong register buffers, using an iterative bottom-up merge.
- Adds per-job key length, ascending/descending mode, guaranteed stability, a busy flag and a valid/ready streamed output alongside the parallel result.
- Sits between the rotation generator and the BWT last-column extractor.

Parameters:
- COLUMN, 3: bytes per element. Byte [COLUMN-1] is the most significant.
- LOG_LEN, 3: log2 of element count; legal range 1..8.
- STRING_LEN, 1<<LOG_LEN: element count; derived, never overridden.
- SW, $clog2(COLUMN+1): width of sort_num.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- sort_num  in  SW  number of MS bytes compared; 0 or >COLUMN means all bytes; latched on start.
- descend  in  1  1 = descending order; latched on start.
- data_in  in  STRING_LEN x COLUMN*8  unpacked input array; latched on start.
- data_out  out  STRING_LEN x COLUMN*8  sorted array; held until the next job completes.
- sorted  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  stream element valid.
- out_ready  in  1  downstream accept.
- out_data  out  COLUMN*8  stream element, index 0 first.
- out_last  out  1  high with the final stream element.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, all buffers and data_out cleared to 0; sorted, busy, out_valid, out_last = 0; all counters 0. Reset mid-job aborts with no partial output.
- State IDLE: start=1 loads data_in into buffer A, latches sort_num and descend, sets pass=0, k=0, goes to MERGE. When start=0, nothing changes.
- State MERGE: writes exactly one destination element per cycle. Run width w = 2^pass. For dst index k, the block base is k with its low pass+1 bits cleared. The left pointer spans [base, base+w) and the right pointer spans [base+w, base+2w).
  - Take left when the right run is exhausted, or when the left run is not exhausted and key(L) <= key(R) (ascending) or key(L) >= key(R) (descending). Ties always take left, which makes the sort stable.
  - Key comparison is an unsigned compare of the top min(sort_num, COLUMN) bytes; the full element is still moved.
  - When k == STRING_LEN-1: k=0, swap source and destination, pass++.
  - When pass == LOG_LEN-1 and k == STRING_LEN-1: the final destination is copied into data_out, sorted pulses next cycle, state goes to OUT.
- MERGE duration is exactly LOG_LEN*STRING_LEN cycles.
- Latency: if start is sampled at edge 0, sorted is high in the cycle after edge LOG_LEN*STRING_LEN. For defaults that is 24 cycles.
- State OUT:
  - out_valid=1 and out_data=data_out[idx], with idx starting at 0.
  - On out_valid & out_ready, idx increments.
  - out_last = (idx == STRING_LEN-1).
  - A handshake with out_last high returns to IDLE, and out_valid drops in the next cycle.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- busy=1 in MERGE and OUT. start is ignored while busy, with no queueing.
- Changes to data_in, sort_num or descend after the start cycle have no effect on the running job.
- sort_num ≥ COLUMN+1 or 0 compares all bytes. With sort_num=1 only byte [COLUMN-1] is compared; equal keys keep their input order.
- Arithmetic: all counters are LOG_LEN+1 bits, and pointer comparisons use block-relative bounds so there is no wrap-around. The descending compare swaps operands only; there is no negation.

Test Plan:
- Defaults, ascending, sort_num=0, data_in bytes-as-values {7,3,5,1,6,2,4,0} on byte 2 with lower bytes 0 -> sorted pulse at cycle 25 after start; data_out = {0,1,2,3,4,5,6,7}<<16; stream emits 8 beats with out_out_ready=1 and out_last on the 8th.
- Stability: elements 0x010003, 0x010001, 0x000002, 0x010002 (rest 0xFFFFFF), sort_num=1 -> keys 01 keep input order, giving 0x000002 ... then 0x010003, 0x010001, 0x010002 in original order; with sort_num=3 -> 0x010001, 0x010002, 0x010003.
- descend=1 on input {0..7}<<16 -> data_out = {7..0}<<16; all-equal input 0xAAAAAA -> output unchanged, sorted still at cycle 25.
- Backpressure: out_ready toggled 1,0,0,1,... -> each element is emitted exactly once and in order, out_data stays stable while stalled, and busy drops the cycle after the last handshake. A second start while busy is ignored: data_out is unchanged and there is no extra sorted pulse.
- Reset mid-MERGE (rst low at cycle 10) -> busy=0, data_out=0, no sorted pulse; a new start then completes normally in 24 cycles.
- Parameter sweep: LOG_LEN=1 and LOG_LEN=5 with COLUMN=4, random data compared against a reference stable sort -> match, with sorted latency of 2 and 160 cycles respectively.

Source files
------------

// File: rtl/merge_sort_iter_if.sv
// Job/result bundle for merge_sort_iter: job launch, parallel result and
// the valid/ready element stream towards the BWT last-column extractor.
interface merge_sort_iter_if #(
    parameter int COLUMN  = 3,
    parameter int LOG_LEN = 3
);
    localparam int STRING_LEN = 1 << LOG_LEN;
    localparam int SW         = $clog2(COLUMN + 1);

    logic                start;
    logic [SW-1:0]       sort_num;
    logic                descend;
    logic [COLUMN*8-1:0] data_in  [STRING_LEN];
    logic [COLUMN*8-1:0] data_out [STRING_LEN];
    logic                sorted;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [COLUMN*8-1:0] out_data;
    logic                out_last;

    modport master (
        output start, sort_num, descend, data_in, out_ready,
        input  data_out, sorted, busy, out_valid, out_data, out_last
    );

    modport slave (
        input  start, sort_num, descend, data_in, out_ready,
        output data_out, sorted, busy, out_valid, out_data, out_last
    );
endinterface

// File: rtl/merge_sort_iter.sv
// Iterative bottom-up stable merge sort of 2^LOG_LEN multi-byte elements using
// one shared comparator, ping-pong register buffers and a streamed result.
module merge_sort_iter #(
    parameter int COLUMN  = 3,
    parameter int LOG_LEN = 3
) (
    input logic              clk,
    input logic              rst,
    merge_sort_iter_if.slave bus
);
    localparam int STRING_LEN = 1 << LOG_LEN;
    localparam int SW         = $clog2(COLUMN + 1);
    localparam int DW         = COLUMN * 8;
    localparam int CW         = LOG_LEN + 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(STRING_LEN - 1);
    localparam logic [CW-1:0] LAST_PASS = CW'(LOG_LEN - 1);

    typedef enum logic [1:0] {IDLE, MERGE, OUT} state_t;

    state_t        state;
    logic [DW-1:0] buf_a    [STRING_LEN];
    logic [DW-1:0] buf_b    [STRING_LEN];
    logic [DW-1:0] data_out [STRING_LEN];
    logic          src_sel;
    logic [DW-1:0] key_mask;
    logic          desc_q;
    logic [CW-1:0] pass, k, l_off, r_off, idx;
    logic          sorted, out_valid;

    logic [CW-1:0]      run_w, blk_mask, base;
    logic [LOG_LEN-1:0] l_pos, r_pos;
    logic               l_exh, r_exh, blk_end, take_left;
    logic [DW-1:0]      l_elem, r_elem, l_key, r_key, merged;

    // Only the top min(n, COLUMN) bytes take part in the key; 0 or oversize means all.
    function automatic logic [DW-1:0] make_mask(input logic [SW-1:0] n);
        logic [DW-1:0] m;
        int            nb;
        nb = (n == '0 || int'(n) > COLUMN) ? COLUMN : int'(n);
        m  = '0;
        for (int b = 0; b < COLUMN; b++)
            if (b >= COLUMN - nb) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    always_comb begin
        run_w     = CW'(1) << pass;
        blk_mask  = (run_w << 1) - CW'(1);
        base      = k & ~blk_mask;
        blk_end   = ((k & blk_mask) == blk_mask);
        l_pos     = LOG_LEN'(base + l_off);
        r_pos     = LOG_LEN'(base + run_w + r_off);
        l_exh     = (l_off == run_w);
        r_exh     = (r_off == run_w);
        l_elem    = src_sel ? buf_b[l_pos] : buf_a[l_pos];
        r_elem    = src_sel ? buf_b[r_pos] : buf_a[r_pos];
        l_key     = l_elem & key_mask;
        r_key     = r_elem & key_mask;
        // Ties go left so equal keys keep their input order.
        take_left = r_exh || (!l_exh && (desc_q ? (l_key >= r_key) : (l_key <= r_key)));
        merged    = take_left ? l_elem : r_elem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_sel   <= 1'b0;
            key_mask  <= '0;
            desc_q    <= 1'b0;
            pass      <= '0;
            k         <= '0;
            l_off     <= '0;
            r_off     <= '0;
            idx       <= '0;
            sorted    <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < STRING_LEN; i++) begin
                buf_a[i]    <= '0;
                buf_b[i]    <= '0;
                data_out[i] <= '0;
            end
        end else begin
            sorted <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < STRING_LEN; i++) buf_a[i] <= bus.data_in[i];
                        key_mask <= make_mask(bus.sort_num);
                        desc_q   <= bus.descend;
                        src_sel  <= 1'b0;
                        pass     <= '0;
                        k        <= '0;
                        l_off    <= '0;
                        r_off    <= '0;
                        state    <= MERGE;
                    end
                end
                MERGE: begin
                    if (src_sel) buf_a[k[LOG_LEN-1:0]] <= merged;
                    else         buf_b[k[LOG_LEN-1:0]] <= merged;
                    if (take_left) l_off <= l_off + CW'(1);
                    else           r_off <= r_off + CW'(1);
                    if (blk_end) begin
                        l_off <= '0;
                        r_off <= '0;
                    end
                    if (k == LAST_IDX) begin
                        k       <= '0;
                        src_sel <= ~src_sel;
                        pass    <= pass + CW'(1);
                        // The element written this cycle is the last one, so bypass it.
                        if (pass == LAST_PASS) begin
                            for (int i = 0; i < STRING_LEN; i++)
                                data_out[i] <= (i == STRING_LEN - 1) ? merged
                                             : (src_sel ? buf_a[i] : buf_b[i]);
                            sorted    <= 1'b1;
                            out_valid <= 1'b1;
                            idx       <= '0;
                            state     <= OUT;
                        end
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            idx       <= '0;
                            state     <= IDLE;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < STRING_LEN; g++) begin : g_out
        assign bus.data_out[g] = data_out[g];
    end

    assign bus.sorted    = sorted;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_out[idx[LOG_LEN-1:0]];
    assign bus.out_last  = out_valid && (idx == LAST_IDX);
endmodule
